// File: rtl/register_file.sv
// RV32I architectural register file with write-through bypass and a
// per-register in-flight write scoreboard that drives the decode stall.
module register_file #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_addr,
    input  logic             rs1_used,
    output logic [WIDTH-1:0] rs1_data,
    input  logic [4:0]       rs2_addr,
    input  logic             rs2_used,
    output logic [WIDTH-1:0] rs2_data,
    input  logic             wr_en,
    input  logic [4:0]       rd_addr,
    input  logic [WIDTH-1:0] rd_data,
    input  logic             issue_en,
    input  logic [4:0]       issue_rd,
    output logic             issue_ready,
    output logic             stall
);

    // Issue handshake: an issue is accepted on a rising edge when issue_en is
    // high and issue_ready is high; issue_ready never depends on issue_en, and
    // an issue presented while issue_ready is low is dropped.

    logic [WIDTH-1:0] regs [1:31];
    logic [1:0]       cnt  [1:31];

    logic [31:1] inc;
    logic [31:1] dec;

    logic [1:0] rs1_cnt;
    logic [1:0] rs2_cnt;
    logic [1:0] issue_cnt;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       hazard_rs1;
    logic       hazard_rs2;

    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 1; r < 32; r++) begin
            inc[r] = issue_en && (issue_rd == 5'(r)) && (cnt[r] != 2'd3);
            dec[r] = wr_en && (rd_addr == 5'(r)) && (cnt[r] != 2'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 1; r < 32; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
        end else begin
            if (wr_en && (rd_addr != 5'd0)) begin
                regs[rd_addr] <= rd_data;
            end
            for (int r = 1; r < 32; r++) begin
                if (inc[r] && !dec[r]) begin
                    cnt[r] <= cnt[r] + 2'd1;
                end else if (dec[r] && !inc[r]) begin
                    cnt[r] <= cnt[r] - 2'd1;
                end
            end
        end
    end

    // x0 has no storage: its counter reads as zero and its data as zero.
    always_comb begin
        rs1_cnt   = (rs1_addr == 5'd0) ? 2'd0 : cnt[rs1_addr];
        rs2_cnt   = (rs2_addr == 5'd0) ? 2'd0 : cnt[rs2_addr];
        issue_cnt = (issue_rd == 5'd0) ? 2'd0 : cnt[issue_rd];
        rs1_hit   = wr_en && (rd_addr == rs1_addr);
        rs2_hit   = wr_en && (rd_addr == rs2_addr);

        if (rs1_addr == 5'd0) begin
            rs1_data = '0;
        end else if (rs1_hit) begin
            rs1_data = rd_data;
        end else begin
            rs1_data = regs[rs1_addr];
        end

        if (rs2_addr == 5'd0) begin
            rs2_data = '0;
        end else if (rs2_hit) begin
            rs2_data = rd_data;
        end else begin
            rs2_data = regs[rs2_addr];
        end

        // The bypass only covers the producer of the last outstanding write.
        hazard_rs1 = rs1_used && (rs1_addr != 5'd0) && (rs1_cnt != 2'd0) &&
                     !(rs1_hit && (rs1_cnt == 2'd1));
        hazard_rs2 = rs2_used && (rs2_addr != 5'd0) && (rs2_cnt != 2'd0) &&
                     !(rs2_hit && (rs2_cnt == 2'd1));
        stall       = hazard_rs1 || hazard_rs2;
        issue_ready = (issue_cnt != 2'd3);
    end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset state, bypass, x0 handling,
// pending-write stalls, counter saturation and reset mid-operation.
module tb_register_file;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic [4:0]       rs1_addr;
    logic             rs1_used;
    logic [WIDTH-1:0] rs1_data;
    logic [4:0]       rs2_addr;
    logic             rs2_used;
    logic [WIDTH-1:0] rs2_data;
    logic             wr_en;
    logic [4:0]       rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             issue_en;
    logic [4:0]       issue_rd;
    logic             issue_ready;
    logic             stall;

    int checks;
    int errors;
    logic [WIDTH-1:0] exp_q[$];

    register_file #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .rs1_addr(rs1_addr), .rs1_used(rs1_used), .rs1_data(rs1_data),
        .rs2_addr(rs2_addr), .rs2_used(rs2_used), .rs2_data(rs2_data),
        .wr_en(wr_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .issue_ready(issue_ready), .stall(stall)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    // driver tasks: inputs change on the falling edge, checks follow #1 later
    task automatic idle();
        reset    = 1'b1;
        rs1_addr = 5'd0; rs1_used = 1'b0;
        rs2_addr = 5'd0; rs2_used = 1'b0;
        wr_en    = 1'b0; rd_addr  = 5'd0; rd_data = '0;
        issue_en = 1'b0; issue_rd = 5'd0;
    endtask

    task automatic do_issue(input logic [4:0] r);
        @(negedge clk);
        idle();
        issue_en = 1'b1;
        issue_rd = r;
    endtask

    task automatic do_write(input logic [4:0] r, input logic [WIDTH-1:0] d);
        @(negedge clk);
        idle();
        wr_en   = 1'b1;
        rd_addr = r;
        rd_data = d;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(31 - a);
            rs1_used = 1'b1;
            rs2_used = 1'b1;
            issue_rd = 5'(a);
            #1;
            checks++;
            if (rs1_data !== 32'h0 || rs2_data !== 32'h0 || stall !== 1'b0 || issue_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_state a=%0d: rs1=%h rs2=%h stall=%b ready=%b, required 0 0 0 1",
                         a, rs1_data, rs2_data, stall, issue_ready);
            end
        end
    endtask

    task automatic test_bypass();
        do_write(5'd5, 32'hDEADBEEF);
        rs1_addr = 5'd5;
        #1;
        checks++;
        if (rs1_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_x5: got %h required deadbeef", rs1_data);
        end
        @(negedge clk);
        idle();
        rs1_addr = 5'd5;
        #1;
        checks++;
        if (rs1_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL stored_x5: got %h required deadbeef", rs1_data);
        end
        do_write(5'd0, 32'h12345678);
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        #1;
        checks++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
            errors++;
            $display("FAIL x0_bypass: got %h %h required 0", rs1_data, rs2_data);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (rs1_data !== 32'h0) begin
            errors++;
            $display("FAIL x0_stored: got %h required 0", rs1_data);
        end
    endtask

    task automatic test_pending();
        do_issue(5'd7);
        @(negedge clk);
        idle();
        rs2_addr = 5'd7;
        rs2_used = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL stall_x7_used: got %b required 1", stall);
        end
        rs2_used = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL stall_x7_unused: got %b required 0", stall);
        end
        rs2_used = 1'b1;
        wr_en    = 1'b1;
        rd_addr  = 5'd7;
        rd_data  = 32'h55;
        #1;
        checks++;
        if (stall !== 1'b0 || rs2_data !== 32'h55) begin
            errors++;
            $display("FAIL writeback_x7: stall=%b data=%h required 0 00000055", stall, rs2_data);
        end
        @(negedge clk);
        idle();
        rs2_addr = 5'd7;
        rs2_used = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || rs2_data !== 32'h55) begin
            errors++;
            $display("FAIL after_wb_x7: stall=%b data=%h required 0 00000055", stall, rs2_data);
        end
    endtask

    task automatic test_two_pending();
        do_issue(5'd3);
        do_issue(5'd3);
        do_write(5'd3, 32'h31);
        rs1_addr = 5'd3;
        rs1_used = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL x3_first_wb: stall=%b required 1", stall);
        end
        do_write(5'd3, 32'h32);
        rs1_addr = 5'd3;
        rs1_used = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || rs1_data !== 32'h32) begin
            errors++;
            $display("FAIL x3_second_wb: stall=%b data=%h required 0 00000032", stall, rs1_data);
        end
        @(negedge clk);
        idle();
        rs1_addr = 5'd3;
        rs1_used = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL x3_drained: stall=%b required 0", stall);
        end
    endtask

    task automatic test_saturate();
        do_issue(5'd9);
        do_issue(5'd9);
        do_issue(5'd9);
        @(negedge clk);
        idle();
        issue_rd = 5'd9;
        #1;
        checks++;
        if (issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL x9_full: ready=%b required 0", issue_ready);
        end
        do_issue(5'd9);
        #1;
        checks++;
        if (issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL x9_fourth_issue: ready=%b required 0", issue_ready);
        end
        @(negedge clk);
        idle();
        issue_rd = 5'd9;
        #1;
        checks++;
        if (issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL x9_after_drop: ready=%b required 0", issue_ready);
        end
        do_write(5'd9, 32'h90);
        @(negedge clk);
        idle();
        issue_rd = 5'd9;
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL x9_one_wb: ready=%b required 1", issue_ready);
        end
        // simultaneous issue and write: counter stays at 2
        @(negedge clk);
        idle();
        issue_en = 1'b1; issue_rd = 5'd9;
        wr_en    = 1'b1; rd_addr  = 5'd9; rd_data = 32'h91;
        @(negedge clk);
        idle();
        issue_rd = 5'd9;
        rs1_addr = 5'd9;
        rs1_used = 1'b1;
        #1;
        checks++;
        if (issue_ready !== 1'b1 || stall !== 1'b1) begin
            errors++;
            $display("FAIL x9_issue_and_wb: ready=%b stall=%b required 1 1", issue_ready, stall);
        end
        do_issue(5'd9);
        @(negedge clk);
        idle();
        issue_rd = 5'd9;
        #1;
        checks++;
        if (issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL x9_refill: ready=%b required 0", issue_ready);
        end
        do_write(5'd9, 32'h92);
        do_write(5'd9, 32'h93);
        do_write(5'd9, 32'h94);
        @(negedge clk);
        idle();
        rs1_addr = 5'd9;
        rs1_used = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || rs1_data !== 32'h94) begin
            errors++;
            $display("FAIL x9_drained: stall=%b data=%h required 0 00000094", stall, rs1_data);
        end
    endtask

    task automatic test_same_cycle_issue();
        // issuing instruction reading its own destination does not stall
        do_issue(5'd12);
        rs1_addr = 5'd12;
        rs1_used = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL x12_self_issue: stall=%b required 0", stall);
        end
        @(negedge clk);
        idle();
        rs2_addr = 5'd12;
        rs2_used = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL x12_next_cycle: stall=%b required 1", stall);
        end
        do_write(5'd12, 32'hC);
        // write with nothing pending must not underflow the counter
        do_write(5'd20, 32'h2020);
        @(negedge clk);
        idle();
        rs1_addr = 5'd20; rs1_used = 1'b1;
        rs2_addr = 5'd12; rs2_used = 1'b1;
        issue_rd = 5'd20;
        #1;
        checks++;
        if (stall !== 1'b0 || issue_ready !== 1'b1 || rs1_data !== 32'h2020) begin
            errors++;
            $display("FAIL idle_write_x20: stall=%b ready=%b data=%h required 0 1 00002020",
                     stall, issue_ready, rs1_data);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 8; i++) begin
            do_write(5'(i), 32'hA000_0000 + 32'(i * 17));
            exp_q.push_back(32'hA000_0000 + 32'(i * 17));
        end
        for (int i = 1; i <= 8; i++) begin
            logic [WIDTH-1:0] exp;
            @(negedge clk);
            idle();
            rs1_addr = 5'(i);
            rs2_addr = 5'(i);
            exp = exp_q.pop_front();
            #1;
            checks++;
            if (rs1_data !== exp || rs2_data !== exp) begin
                errors++;
                $display("FAIL b2b_x%0d: got %h %h required %h", i, rs1_data, rs2_data, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_write(5'd4, 32'hA5);
        do_issue(5'd4);
        // reset wins over a same-cycle write and issue
        @(negedge clk);
        idle();
        reset    = 1'b0;
        wr_en    = 1'b1; rd_addr = 5'd4; rd_data = 32'hFF;
        issue_en = 1'b1; issue_rd = 5'd4;
        @(negedge clk);
        idle();
        rs1_addr = 5'd4;
        rs1_used = 1'b1;
        rs2_addr = 5'd5;
        #1;
        checks++;
        if (rs1_data !== 32'h0 || stall !== 1'b0 || rs2_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_x4: data=%h stall=%b x5=%h required 0 0 0", rs1_data, stall, rs2_data);
        end
        do_write(5'd4, 32'h77);
        @(negedge clk);
        idle();
        rs1_addr = 5'd4;
        rs1_used = 1'b1;
        issue_rd = 5'd4;
        #1;
        checks++;
        if (rs1_data !== 32'h77 || stall !== 1'b0 || issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_wb_x4: data=%h stall=%b ready=%b required 00000077 0 1",
                     rs1_data, stall, issue_ready);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        test_reset();
        test_bypass();
        test_pending();
        test_two_pending();
        test_saturate();
        test_same_cycle_issue();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
